// File: rtl/addsub_pkg.sv
// Shared types and constants for the bit-serial add/subtract engine.
//   state_e : controller FSM states
//   OP_ADD / OP_SUB : encoding of the 'sub' operation select
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/fa_cell.sv
// 1-bit full adder, purely combinational. Time-shared by the serial controller.
//   a, b, cin : addend bits and carry in
//   s, cout   : sum bit and carry out
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract engine. One full-adder cell processes the operands
// LSB first over WIDTH cycles; subtract is A + ~B + 1.
//   clk, rst_n           : clock, async active-low reset
//   in_valid / in_ready  : operand handshake (a, b, sub)
//   out_valid / out_ready: result handshake (s, cout, ovf)
//   cout                 : carry out of MSB (subtract: 1 = no borrow)
//   ovf                  : signed overflow
//   busy                 : operation in flight or result waiting
module serial_addsub_ctrl
  import addsub_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             sub_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] s_q;
  logic             cout_q, ovf_q;

  logic fa_s, fa_co;
  logic last_bit;

  assign last_bit = (state_q == RUN) && (cnt == LAST);

  fa_cell u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0] ^ sub_q),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_co)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_bit)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Sum bits enter a_sh from the MSB as operand bits leave at the LSB, so
  // after WIDTH shifts a_sh holds the finished result with no extra register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sub_q   <= OP_ADD;
      carry_q <= 1'b0;
      cnt     <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_sh    <= a;
          b_sh    <= b;
          sub_q   <= sub;
          carry_q <= (sub == OP_SUB);
          cnt     <= '0;
        end
        RUN: begin
          a_sh    <= {fa_s, a_sh[WIDTH-1:1]};
          b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
          carry_q <= fa_co;
          cnt     <= cnt + CNT_W'(1);
          if (last_bit) begin
            s_q    <= {fa_s, a_sh[WIDTH-1:1]};
            cout_q <= fa_co;
            // carry_q is the carry into the MSB on this edge
            ovf_q  <= carry_q ^ fa_co;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
module tb_serial_addsub_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic [W-1:0] a, b;
  logic         sub;
  logic         out_valid, out_ready;
  logic [W-1:0] s;
  logic         cout, ovf, busy;

  int n_cmp = 0;
  int n_err = 0;

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic op,
                       output logic [W-1:0] es, output logic ec, output logic eo);
    int ux, uy, sx, sy, r, sr;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (!op) begin
      r  = ux + uy;
      ec = (r >= (1 << W));
      sr = sx + sy;
    end else begin
      r  = ux - uy + (1 << W);
      ec = (ux >= uy);
      sr = sx - sy;
    end
    es = W'(r);
    eo = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
  endtask

  // Issue one operation, check latency, hold under backpressure, handshake.
  task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                       input logic op, input logic [W-1:0] es, input logic ec,
                       input logic eo, input int hold, input bit pulse);
    int lat;
    @(negedge clk);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    a = ta; b = tb_; sub = op; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (pulse && lat == 2) begin
        a = ~ta; b = ta; sub = ~op; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    chk({tag, ".latency"}, 32'(lat), 32'(W));
    chk({tag, ".s"},    32'(s),    32'(es));
    chk({tag, ".cout"}, 32'(cout), 32'(ec));
    chk({tag, ".ovf"},  32'(ovf),  32'(eo));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".hold_s"},     32'(s),         32'(es));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".post_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".post_ready"}, 32'(in_ready),  32'd1);
    chk({tag, ".post_s"},     32'(s),         32'(es));
  endtask

  initial begin
    logic [W-1:0] ra, rb, es;
    logic         rs, ec, eo;
    bit           seen;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0;
    #12;
    chk("rst.in_ready",  32'(in_ready),  32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.busy",      32'(busy),      32'd0);
    chk("rst.s",         32'(s),         32'd0);
    chk("rst.cout_ovf",  32'({cout, ovf}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("add",    8'd5,   8'd3, 1'b0, 8'd8,   1'b0, 1'b0, 0, 1'b0);
    do_op("borrow", 8'd0,   8'd1, 1'b1, 8'd255, 1'b0, 1'b0, 0, 1'b0);
    do_op("wrap",   8'd255, 8'd1, 1'b0, 8'd0,   1'b1, 1'b0, 0, 1'b0);
    do_op("ovf_add",8'd127, 8'd1, 1'b0, 8'd128, 1'b0, 1'b1, 0, 1'b0);
    do_op("ovf_sub",8'd128, 8'd1, 1'b1, 8'd127, 1'b1, 1'b1, 0, 1'b0);
    do_op("bp",     8'd17,  8'd42,1'b0, 8'd59,  1'b0, 1'b0, 5, 1'b1);

    // Reset asynchronously partway through 200+100.
    @(negedge clk);
    a = 8'd200; b = 8'd100; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst.out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst.in_ready",  32'(in_ready),  32'd1);
    chk("mid_rst.busy",      32'(busy),      32'd0);
    chk("mid_rst.s",         32'(s),         32'd0);
    chk("mid_rst.cout_ovf",  32'({cout, ovf}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 2*W; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("mid_rst.no_valid", 32'(seen), 32'd0);
    do_op("fresh", 8'd200, 8'd100, 1'b0, 8'd44, 1'b1, 1'b0, 0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom);
      model(ra, rb, rs, es, ec, eo);
      do_op($sformatf("rnd%0d", k), ra, rb, rs, es, ec, eo,
            int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
